spi_flash_sequencer: RTL and testbench



---
 rtl/fpga20_spi_pkg.sv | 31 +++
 rtl/spi_flash_sequencer.sv | 173 +++++++++++++++++
 tb/tb_spi_flash_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga20_spi_pkg.sv
// -----------------------------------------------------------------------------
// fpga20_spi_pkg
// Shared definitions for the SPI flash read path:
//   - SPI flash opcodes used by the read sequencer
//   - state encoding of spi_flash_sequencer
//   - status bit positions shared with the CPU-facing I/O register block
// -----------------------------------------------------------------------------
package fpga20_spi_pkg;

  // Flash read opcodes
  localparam logic [7:0] SPI_OP_READ      = 8'h03;
  localparam logic [7:0] SPI_OP_FAST_READ = 8'h0B;

  // Sequencer states. ST_DUMMY is only entered when fast read is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_A2     = 3'd2,
    ST_A1     = 3'd3,
    ST_A0     = 3'd4,
    ST_DUMMY  = 3'd5,
    ST_DATA   = 3'd6,
    ST_FINISH = 3'd7
  } seq_state_t;

  // Status register bit positions as seen by the CPU I/O register block
  localparam int unsigned STAT_BUSY_BIT      = 0;
  localparam int unsigned STAT_DONE_BIT      = 1;
  localparam int unsigned STAT_OUT_VALID_BIT = 2;

endpackage

// File: rtl/spi_flash_sequencer.sv
// -----------------------------------------------------------------------------
// spi_flash_sequencer
// Autonomous SPI flash read sequencer. On START it owns the spi_master
// WISHBONE slave port, sends the read opcode and a 24-bit address, then reads
// LEN data bytes and hands them out on a one-byte valid/ready stream.
//
// Build option: define SPI_FAST_READ_EN to use opcode 0x0B with one dummy
// byte after the address; otherwise opcode 0x03 with no dummy byte.
//
// Ports:
//   CLK1, RST_N            clock, asynchronous active-low reset
//   START, ADDR, LEN       transfer request (honoured only when idle)
//   ABORT                  level, ends the active transfer
//   BUSY, DONE             transfer status (DONE is a one-cycle pulse)
//   OUT_DATA/VALID/READY   received byte stream
//   WB_CYC/STB/WE/DAT_O    WISHBONE master outputs to spi_master
//   WB_DAT_I, WB_ACK       WISHBONE inputs from spi_master
// -----------------------------------------------------------------------------
module spi_flash_sequencer
  import fpga20_spi_pkg::*;
#(
  parameter logic [7:0] DUMMY_FILL = 8'hFF
) (
  input  logic        CLK1,
  input  logic        RST_N,
  input  logic        START,
  input  logic [23:0] ADDR,
  input  logic [15:0] LEN,
  input  logic        ABORT,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        WB_CYC,
  output logic        WB_STB,
  output logic        WB_WE,
  output logic [7:0]  WB_DAT_O,
  input  logic [7:0]  WB_DAT_I,
  input  logic        WB_ACK
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] OPCODE = SPI_OP_FAST_READ;
`else
  localparam logic [7:0] OPCODE = SPI_OP_READ;
`endif

  seq_state_t  state;
  seq_state_t  next_state;
  logic [23:0] addr_q;
  logic [15:0] remaining;
  logic [7:0]  req_byte;

  // Byte to send in the current state and the state that follows its ACK.
  // Reads and the dummy cycle drive DUMMY_FILL.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    next_state = ST_FINISH;
    req_byte   = DUMMY_FILL;
    case (state)
      ST_CMD: begin
        next_state = ST_A2;
        req_byte   = OPCODE;
      end
      ST_A2: begin
        next_state = ST_A1;
        req_byte   = addr_q[23:16];
      end
      ST_A1: begin
        next_state = ST_A0;
        req_byte   = addr_q[15:8];
      end
      ST_A0: begin
        req_byte   = addr_q[7:0];
`ifdef SPI_FAST_READ_EN
        next_state = ST_DUMMY;
`else
        next_state = ST_DATA;
`endif
      end
`ifdef SPI_FAST_READ_EN
      ST_DUMMY: next_state = ST_DATA;
`endif
      default: ;
    endcase
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge CLK1 or negedge RST_N) begin
    if (!RST_N) begin
      // Asynchronous reset drops CYC/STB at once; any in-flight byte is lost.
      state     <= ST_IDLE;
      addr_q    <= '0;
      remaining <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      WB_CYC    <= 1'b0;
      WB_STB    <= 1'b0;
      WB_WE     <= 1'b0;
      WB_DAT_O  <= '0;
    end else begin
      DONE <= 1'b0;
      // Consumption; a byte loaded later in this block overrides the clear.
      if (OUT_VALID && OUT_READY) OUT_VALID <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (START) begin
            if (LEN == 16'd0) begin
              DONE <= 1'b1;
            end else begin
              // The opcode request goes out on the very next cycle.
              addr_q    <= ADDR;
              remaining <= LEN;
              BUSY      <= 1'b1;
              WB_CYC    <= 1'b1;
              WB_STB    <= 1'b1;
              WB_WE     <= 1'b1;
              WB_DAT_O  <= OPCODE;
              state     <= ST_CMD;
            end
          end
        end

        ST_FINISH: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          if (WB_STB) begin
            // Request in flight: hold it until ACK, even when aborting.
            if (WB_ACK) begin
              WB_STB <= 1'b0;
              if (ABORT) begin
                state     <= ST_FINISH;
                WB_CYC    <= 1'b0;
                OUT_VALID <= 1'b0;
              end else if (state == ST_DATA) begin
                OUT_DATA  <= WB_DAT_I;
                OUT_VALID <= 1'b1;
                remaining <= remaining - 16'd1;
                if (remaining == 16'd1) begin
                  state  <= ST_FINISH;
                  WB_CYC <= 1'b0;
                end
              end else begin
                state <= next_state;
              end
            end
          end else if (ABORT) begin
            state     <= ST_FINISH;
            WB_CYC    <= 1'b0;
            OUT_VALID <= 1'b0;
          end else if (state != ST_DATA || !OUT_VALID || OUT_READY) begin
            // STB was low for the cycle after the previous ACK; a read only
            // starts when the holding register is empty or being drained.
            WB_STB   <= 1'b1;
            WB_WE    <= (state != ST_DATA);
            WB_DAT_O <= req_byte;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_sequencer
// Self-checking bench for spi_flash_sequencer. A WISHBONE slave model with a
// programmable ACK delay logs every request and returns bytes from a data
// table; a consumer model drives OUT_READY. Each transfer is compared with
// the expected request sequence, returned bytes, DONE pulses and CYC framing.
// Follows SPI_FAST_READ_EN when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_flash_sequencer;

`ifdef SPI_FAST_READ_EN
  localparam int HDR = 5;
  localparam logic [7:0] OPC = 8'h0B;
`else
  localparam int HDR = 4;
  localparam logic [7:0] OPC = 8'h03;
`endif

  logic        CLK1 = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [23:0] ADDR = '0;
  logic [15:0] LEN = '0;
  logic        ABORT = 1'b0;
  logic        BUSY, DONE, OUT_VALID;
  logic [7:0]  OUT_DATA;
  logic        OUT_READY = 1'b0;
  logic        WB_CYC, WB_STB, WB_WE;
  logic [7:0]  WB_DAT_O;
  logic [7:0]  WB_DAT_I = '0;
  logic        WB_ACK = 1'b0;

  spi_flash_sequencer dut (
    .CLK1(CLK1), .RST_N(RST_N), .START(START), .ADDR(ADDR), .LEN(LEN),
    .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .WB_CYC(WB_CYC),
    .WB_STB(WB_STB), .WB_WE(WB_WE), .WB_DAT_O(WB_DAT_O),
    .WB_DAT_I(WB_DAT_I), .WB_ACK(WB_ACK)
  );

  always #5 CLK1 = ~CLK1;

  // Bench configuration (written by the stimulus process only)
  int         ack_dly = 0;
  int         rdy_pct = 100;
  bit         rdy_hold = 1'b0;
  logic [7:0] data_tab [0:4095];

  // Observations (written by the monitor process only)
  logic [7:0] wr_q[$];
  logic [7:0] rx_q[$];
  int req_cnt = 0, rd_idx = 0, done_cnt = 0, cyc_low_busy = 0, proto_err = 0;
  int wcnt = 0;
  bit prev_stb = 1'b0, prev_ack = 1'b0;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Protocol monitor, consumer and WISHBONE slave, all on the falling edge.
  always @(negedge CLK1) begin
    if (!RST_N) begin
      WB_ACK = 1'b0; wcnt = 0; prev_stb = 1'b0; prev_ack = 1'b0;
    end else begin
      if (prev_ack && WB_STB) proto_err++;                 // no gap after ACK
      if (prev_stb && !prev_ack && !WB_STB) proto_err++;   // STB dropped early
      if (WB_STB && !WB_CYC) proto_err++;
      if (!BUSY && WB_CYC) proto_err++;
      if (BUSY && !WB_CYC) cyc_low_busy++;
      if (DONE) done_cnt++;
      OUT_READY = !rdy_hold && ($urandom_range(99) < rdy_pct);
      if (OUT_VALID && OUT_READY) rx_q.push_back(OUT_DATA);
      if (WB_ACK) WB_ACK = 1'b0;
      else if (WB_STB) begin
        if (wcnt >= ack_dly) begin
          WB_ACK = 1'b1; wcnt = 0; req_cnt++;
          if (WB_WE) wr_q.push_back(WB_DAT_O);
          else begin WB_DAT_I = data_tab[rd_idx[11:0]]; rd_idx++; end
        end else wcnt++;
      end
      prev_stb = WB_STB; prev_ack = WB_ACK;
    end
  end

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK1); #1;
      if (DONE) begin seen = 1'b1; break; end
    end
    if (!seen) check({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK1); #1;
      if (!OUT_VALID) break;
    end
    @(posedge CLK1); #1;
  endtask

  task automatic check_rx(input string name, input int rx0, input int rd0, input int n);
    check({name, "_rx_count"}, rx_q.size() - rx0, n);
    for (int j = 0; j < n && rx0 + j < rx_q.size(); j++)
      check({name, "_rx_byte"}, rx_q[rx0 + j], data_tab[(rd0 + j) % 4096]);
  endtask

  // One complete transfer checked against the transaction-level model.
  task automatic run_xfer(input string name, input logic [23:0] a, input int n,
                          input int dly, input int pct, input int exp_stb, input bit poke);
    logic [7:0] hdr [5];
    int wr0, rx0, rd0, req0, done0, cl0, pe0;
    hdr = '{OPC, a[23:16], a[15:8], a[7:0], 8'hFF};
    ack_dly = dly; rdy_pct = pct;
    wr0 = wr_q.size(); rx0 = rx_q.size(); rd0 = rd_idx; req0 = req_cnt;
    done0 = done_cnt; cl0 = cyc_low_busy; pe0 = proto_err;
    @(negedge CLK1); START = 1'b1; ADDR = a; LEN = n[15:0];
    @(posedge CLK1); #1;
    if (n == 0) begin
      check({name, "_len0_done"}, DONE, 1);
      check({name, "_len0_idle"}, {WB_CYC, WB_STB, BUSY}, 0);
    end else begin
      check({name, "_start_ctl"}, {WB_CYC, WB_STB, WB_WE, BUSY}, 4'hF);
      check({name, "_start_op"}, WB_DAT_O, OPC);
    end
    @(negedge CLK1); START = 1'b0;
    if (poke) begin
      @(negedge CLK1);
      if (BUSY) begin START = 1'b1; ADDR = ~a; LEN = 16'd5; end
      @(negedge CLK1); START = 1'b0;
    end
    if (n != 0) begin
      wait_done(name);
      drain();
    end else begin
      repeat (3) @(posedge CLK1);
      #1;
    end
    check({name, "_done_pulses"}, done_cnt - done0, 1);
    check({name, "_requests"}, req_cnt - req0, exp_stb);
    check({name, "_writes"}, wr_q.size() - wr0, (n == 0) ? 0 : HDR);
    for (int j = 0; j < HDR && wr0 + j < wr_q.size(); j++)
      check({name, "_wr_byte"}, wr_q[wr0 + j], hdr[j]);
    check_rx(name, rx0, rd0, n);
    check({name, "_cyc_low_cycles"}, cyc_low_busy - cl0, (n == 0) ? 0 : 1);
    check({name, "_protocol"}, proto_err - pe0, 0);
  endtask

  typedef struct {
    logic [23:0] addr;
    int          len;
    int          dly;
    int          pct;
    int          exp_stb;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int rx0, rd0, req0, done0, cl0, pe0;
    bit hit;

    vecs[0] = '{24'h012345, 3, 0, 100, HDR + 3};
    vecs[1] = '{24'h00BEEF, 0, 0, 100, 0};
    vecs[2] = '{24'hFFFFFF, 1, 2, 100, HDR + 1};
    vecs[3] = '{24'hABCDEF, 5, 1, 50,  HDR + 5};
    vecs[4] = '{24'h800001, 2, 3, 100, HDR + 2};

    for (int i = 0; i < 4096; i++) data_tab[i] = 8'($urandom);
    data_tab[0] = 8'hA5; data_tab[1] = 8'h5A; data_tab[2] = 8'hC3;

    // Reset state
    #7;
    check("reset_outputs", {WB_CYC, WB_STB, WB_WE, BUSY, DONE, OUT_VALID}, 0);
    check("reset_data", {WB_DAT_O, OUT_DATA}, 0);
    @(negedge CLK1); RST_N = 1'b1;
    repeat (2) @(negedge CLK1);

    // ABORT in IDLE is ignored
    done0 = done_cnt;
    ABORT = 1'b1; repeat (3) @(negedge CLK1); ABORT = 1'b0;
    @(posedge CLK1); #1;
    check("idle_abort_ignored", {BUSY, WB_CYC, 8'(done_cnt - done0)}, 0);

    // Directed table
    for (int i = 0; i < 5; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].len, vecs[i].dly,
               vecs[i].pct, vecs[i].exp_stb, 1'b0);

    // Reset pulse while the A1 byte is in flight
    ack_dly = 2; rdy_pct = 100;
    req0 = wr_q.size(); hit = 1'b0;
    @(negedge CLK1); START = 1'b1; ADDR = 24'h123456; LEN = 16'd8;
    @(negedge CLK1); START = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK1); #1;
      if (wr_q.size() - req0 == 2 && WB_STB) begin hit = 1'b1; break; end
    end
    check("rst_reached_a1", hit, 1);
    check("rst_a1_byte", WB_DAT_O, 8'h34);
    #1 RST_N = 1'b0;
    #1;
    check("rst_async_drop", {WB_CYC, WB_STB, BUSY, OUT_VALID}, 0);
    @(negedge CLK1); @(negedge CLK1); RST_N = 1'b1;
    run_xfer("post_reset", 24'hC0FFEE, 2, 1, 100, HDR + 2, 1'b0);

    // Backpressure: READY low after the first byte
    ack_dly = 0; rdy_hold = 1'b1;
    rx0 = rx_q.size(); rd0 = rd_idx; req0 = req_cnt; done0 = done_cnt; hit = 1'b0;
    @(negedge CLK1); START = 1'b1; ADDR = 24'h00A000; LEN = 16'd4;
    @(negedge CLK1); START = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK1); #1;
      if (OUT_VALID) begin hit = 1'b1; break; end
    end
    repeat (20) @(posedge CLK1);
    #1;
    check("bp_first_byte", hit, 1);
    check("bp_stalled_reads", rd_idx - rd0, 1);
    check("bp_no_stb", WB_STB, 0);
    rdy_hold = 1'b0;
    wait_done("bp");
    drain();
    check_rx("bp", rx0, rd0, 4);
    check("bp_requests", req_cnt - req0, HDR + 4);
    check("bp_done_pulses", done_cnt - done0, 1);

    // ABORT while a DATA read is in flight
    ack_dly = 3; rdy_pct = 100;
    rx0 = rx_q.size(); rd0 = rd_idx; done0 = done_cnt; cl0 = cyc_low_busy; pe0 = proto_err; hit = 1'b0;
    @(negedge CLK1); START = 1'b1; ADDR = 24'h000100; LEN = 16'd100;
    @(negedge CLK1); START = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge CLK1); #1;
      if (rd_idx - rd0 == 2 && WB_STB && !WB_WE) begin hit = 1'b1; break; end
    end
    check("abort_reached_data", hit, 1);
    ABORT = 1'b1;
    wait_done("abort");
    check("abort_out_valid", OUT_VALID, 0);
    ABORT = 1'b0;
    @(posedge CLK1); #1;
    check("abort_reads", rd_idx - rd0, 3);
    check_rx("abort", rx0, rd0, 2);
    check("abort_done_pulses", done_cnt - done0, 1);
    check("abort_cyc_low", cyc_low_busy - cl0, 1);
    check("abort_protocol", proto_err - pe0, 0);

    // ABORT while stalled with a byte held: the byte is dropped
    ack_dly = 0; rdy_hold = 1'b1;
    rx0 = rx_q.size(); rd0 = rd_idx; done0 = done_cnt;
    @(negedge CLK1); START = 1'b1; ADDR = 24'h0F0F0F; LEN = 16'd4;
    @(negedge CLK1); START = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK1); #1;
      if (OUT_VALID) break;
    end
    repeat (5) @(posedge CLK1);
    ABORT = 1'b1;
    wait_done("abort_held");
    check("abort_held_valid", OUT_VALID, 0);
    ABORT = 1'b0; rdy_hold = 1'b0;
    repeat (3) @(posedge CLK1);
    #1;
    check("abort_held_rx", rx_q.size() - rx0, 0);
    check("abort_held_reads", rd_idx - rd0, 1);
    check("abort_held_done", done_cnt - done0, 1);

    // Randomized transfers with a stray START while busy
    for (int i = 0; i < 16; i++) begin
      logic [23:0] a;
      int n;
      a = 24'($urandom);
      n = $urandom_range(0, 9);
      run_xfer($sformatf("rnd%0d", i), a, n, $urandom_range(0, 3),
               $urandom_range(30, 100), (n == 0) ? 0 : HDR + n, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
